// File: rtl/split_case_pkg.sv
// Shared encodings and types for the split-case encoder/decoder pair.
// Both lanes carry the same word under different sel-dependent offsets.
package split_case_pkg;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;

  localparam int OFF_A = 5;
  localparam int OFF_B = 6;

  localparam int TRIPLE_DATA_W = 8;

  typedef struct packed {
    logic [1:0]               sel;
    logic [TRIPLE_DATA_W-1:0] a;
    logic [TRIPLE_DATA_W-1:0] b;
  } triple_t;

endpackage

// File: rtl/split_case_inv.sv
// Combinational inverse of the split-case lane encoding.
// Undoes the encoder's offsets on both lanes and flags disagreement.
module split_case_inv
  import split_case_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] da,
  output logic [DATA_W-1:0] db,
  output logic              err
);

  always_comb begin
    da = a;
    db = b;
    unique case (1'b1)
      (sel == SEL_ADD): begin
        da = a - DATA_W'(OFF_A);
        db = b - DATA_W'(OFF_B);
      end
      (sel == SEL_SUB): begin
        da = a + DATA_W'(OFF_A);
        db = b + DATA_W'(OFF_B);
      end
      default: begin
        da = a;
        db = b;
      end
    endcase
  end

  assign err = (da != db);

endmodule

// File: rtl/split_case_decoder.sv
// Two-stage valid/ready decoder for split-case encoded triples,
// with lane cross-check and a saturating mismatch counter.
module split_case_decoder
  import split_case_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [DATA_W-1:0]    in_case_a,
  input  logic [DATA_W-1:0]    in_case_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic              s1_valid;
  logic [1:0]        s1_sel;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s2_valid;

  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] unused_dec_b;
  logic              dec_err;

  logic adv2;
  logic accept;
  logic s1_move;
  logic out_fire;

  split_case_inv #(
    .DATA_W (DATA_W)
  ) u_inv (
    .sel (s1_sel),
    .a   (s1_a),
    .b   (s1_b),
    .da  (dec_a),
    .db  (unused_dec_b),
    .err (dec_err)
  );

  assign adv2      = !s2_valid || out_ready;
  assign s1_move   = s1_valid && adv2;
  assign in_ready  = !rst && (!s1_valid || adv2);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sel    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_sel   <= in_sel;
        s1_a     <= in_case_a;
        s1_b     <= in_case_b;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      // Output regs only move when S2 is free, so held words stay stable.
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= dec_a;
          out_err  <= dec_err;
        end
      end

      if (clr_err) begin
        err_count <= '0;
      end else if (out_fire && out_err && err_count != ERR_MAX) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_split_case_decoder.sv
// Directed bench for split_case_decoder with a queue-based reference
// model checked every cycle plus literal expectations.
module tb_split_case_decoder;
  import split_case_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in_case_a = 8'h00;
  logic [7:0] in_case_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_err;
  logic       clr_err = 1'b0;
  logic [7:0] err_count;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   cyc  = 0;

  split_case_decoder #(
    .DATA_W    (8),
    .ERR_CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_case_a (in_case_a),
    .in_case_b (in_case_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    else
      n_pass++;
  endtask

  function automatic logic [8:0] ref_dec(input logic [1:0] s,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int da;
    int db;
    case (s)
      2'd0: begin
        da = (int'(a) - 5 + 256) % 256;
        db = (int'(b) - 6 + 256) % 256;
      end
      2'd1: begin
        da = (int'(a) + 5) % 256;
        db = (int'(b) + 6) % 256;
      end
      default: begin
        da = int'(a);
        db = int'(b);
      end
    endcase
    return {da != db, da[7:0]};
  endfunction

  function automatic logic exp_ov();
    return q.size() > 0 && q[0].cyc + 1 < cyc;
  endfunction

  function automatic logic exp_ir();
    return !rst && (q.size() < 2 || out_ready);
  endfunction

  task automatic model_step();
    logic       ov;
    logic       ir;
    logic [8:0] r;
    exp_t       e;
    ov = exp_ov();
    ir = exp_ir();
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (ov && out_ready) begin
        if (q[0].e && mcnt < 255) mcnt++;
        void'(q.pop_front());
      end
      if (clr_err) mcnt = 0;
      if (in_valid && ir) begin
        r = ref_dec(in_sel, in_case_a, in_case_b);
        e.d = r[7:0];
        e.e = r[8];
        e.cyc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic compare_step();
    logic ov;
    ov = exp_ov();
    chk("in_ready", 32'(in_ready), 32'(exp_ir()));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("err_count", 32'(err_count), 32'(mcnt));
    if (ov) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_err", 32'(out_err), 32'(q[0].e));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_step();
  end

  task automatic send(input triple_t t);
    in_valid  = 1'b1;
    in_sel    = t.sel;
    in_case_a = t.a;
    in_case_b = t.b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_tot++;
    $display("FAIL send_timeout: in_ready never seen");
    in_valid = 1'b0;
  endtask

  task automatic get(input string nm, input logic [7:0] d, input logic e);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({nm, "_data"}, 32'(out_data), 32'(d));
        chk({nm, "_err"}, 32'(out_err), 32'(e));
        @(posedge clk);
        #1;
        return;
      end
    end
    n_tot++;
    $display("FAIL %s_timeout: out_valid never seen", nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    triple_t    t;
    logic [7:0] w[3];
    logic [7:0] got[$];
    logic       acc;
    int         k;
    int         n_acc;

    w[0] = 8'h01;
    w[1] = 8'h02;
    w[2] = 8'h03;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    t = '{sel: 2'b00, a: 8'h0F, b: 8'h10};
    send(t);
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'h0A);
    chk("t1_err", 32'(out_err), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_cnt", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;

    t = '{sel: 2'b01, a: 8'hFB, b: 8'hFA};
    send(t);
    get("add_wrap", 8'h00, 1'b0);
    t = '{sel: 2'b00, a: 8'h03, b: 8'h04};
    send(t);
    get("sub_wrap", 8'hFE, 1'b0);

    t = '{sel: 2'b00, a: 8'h10, b: 8'h10};
    send(t);
    get("mism", 8'h0B, 1'b1);
    @(negedge clk);
    chk("mism_cnt", 32'(err_count), 32'h1);
    @(posedge clk);
    #1;
    t = '{sel: 2'b10, a: 8'h10, b: 8'h10};
    send(t);
    get("pass_sel", 8'h10, 1'b0);

    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid  = (k < 3);
      in_sel    = 2'b10;
      in_case_a = w[k < 3 ? k : 2];
      in_case_b = w[k < 3 ? k : 2];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    chk("bp_accepts", 32'(k), 32'd2);
    @(negedge clk);
    chk("bp_ready_low", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && got.size() < 3; i++) begin
      in_valid  = (k < 3);
      in_case_a = w[k < 3 ? k : 2];
      in_case_b = w[k < 3 ? k : 2];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_data);
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int j = 0; j < 3; j++)
      chk("bp_order", 32'(j < got.size() ? got[j] : 8'hEE), 32'(w[j]));
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;

    in_valid  = 1'b1;
    in_sel    = 2'b00;
    in_case_a = 8'h10;
    in_case_b = 8'h10;
    n_acc = 0;
    for (int i = 0; i < 1000 && n_acc < 300; i++) begin
      @(negedge clk);
      if (in_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("sat_accepts", 32'(n_acc), 32'd300);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(err_count), 32'hFF);
    @(posedge clk);
    #1;

    t = '{sel: 2'b00, a: 8'h10, b: 8'h10};
    send(t);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        clr_err = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    chk("clr_same_cycle", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;

    send(t);
    get("post_clr", 8'h0B, 1'b1);
    @(negedge clk);
    chk("post_clr_cnt", 32'(err_count), 32'h1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    t = '{sel: 2'b10, a: 8'h55, b: 8'h55};
    send(t);
    t = '{sel: 2'b10, a: 8'h66, b: 8'h66};
    send(t);
    @(negedge clk);
    chk("full_ready_low", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'b10;
    in_case_a = 8'h77;
    in_case_b = 8'h77;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_err_count", 32'(err_count), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_ready_back", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    t = '{sel: 2'b01, a: 8'h2B, b: 8'h2A};
    send(t);
    get("post_rst", 8'h30, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
